// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, default line parameters and divider helper
package uart_pkg;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_e;
  localparam int unsigned DEF_CLK_FREQ   = 50_000_000;
  localparam int unsigned DEF_BAUD       = 115_200;
  localparam int unsigned DEF_OVERSAMPLE = 16;
  function automatic int unsigned calc_div(int unsigned clk_freq, int unsigned baud, int unsigned os);
    int unsigned d;
    d = clk_freq / (baud * os);
    return (d < 1) ? 1 : d;
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider emitting a one-clk oversample tick every DIV clocks
module uart_baud_tick #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic reset,
  output logic tick_o
);
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  logic [W-1:0] cnt_q;
  assign tick_o = (cnt_q == W'(DIV - 1));
  // count 0..DIV-1 and wrap on the tick
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else       cnt_q <= tick_o ? '0 : cnt_q + 1'b1;
endmodule

// File: rtl/uart_rx_unit.sv
// uart_rx_unit: oversampling 8N1 UART receiver with valid/ready byte register and error flags
module uart_rx_unit import uart_pkg::*; #(
  parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
  parameter int unsigned BAUD       = DEF_BAUD,
  parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
);
  localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int SCW = $clog2(OVERSAMPLE);
  localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [SCW-1:0] MID  = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] LAST = SCW'(OVERSAMPLE - 1);
  logic                 tick, rxs, done, ferr, xfer;
  logic [1:0]           sync_q;
  state_e               state_q, state_d;
  logic [SCW-1:0]       sc_q, sc_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d, frame_err_q, frame_err_d, overrun_q, overrun_d;
  uart_baud_tick #(.DIV(DIV)) u_tick (.clk(clk), .reset(reset), .tick_o(tick));
  assign rxs       = sync_q[1];
  assign xfer      = rx_valid_q & rx_ready;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  // state, counters, shifter and holding register; synchroniser idles high
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync_q      <= 2'b11;
      state_q     <= S_IDLE;
      sc_q        <= '0;
      bit_q       <= '0;
      sh_q        <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], uart_rx};
      state_q     <= state_d;
      sc_q        <= sc_d;
      bit_q       <= bit_d;
      sh_q        <= sh_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  // framing FSM: start bit checked at mid-bit, data and stop sampled a full bit later each
  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    done    = 1'b0;
    ferr    = 1'b0;
    case (state_q)
      S_IDLE: if (!rxs) begin
        state_d = S_START;
        sc_d    = '0;
      end
      S_START: if (tick) begin
        sc_d = sc_q + 1'b1;
        if (sc_q == MID) begin
          sc_d    = '0;
          bit_d   = '0;
          state_d = rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: if (tick) begin
        sc_d = (sc_q == LAST) ? '0 : sc_q + 1'b1;
        if (sc_q == LAST) begin
          sh_d    = {rxs, sh_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          state_d = (bit_q == BW'(DATA_BITS - 1)) ? S_STOP : S_DATA;
        end
      end
      S_STOP: if (tick) begin
        sc_d = (sc_q == LAST) ? '0 : sc_q + 1'b1;
        if (sc_q == LAST) begin
          done    = rxs;
          ferr    = !rxs;
          state_d = rxs ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: state_d = rxs ? S_IDLE : S_BREAK;
      default: state_d = S_IDLE;
    endcase
  end
  // holding register and status flags; a transfer in the completion cycle cancels the overrun
  always_comb begin
    rx_data_d   = done ? sh_q : rx_data_q;
    rx_valid_d  = done ? 1'b1 : (xfer ? 1'b0 : rx_valid_q);
    overrun_d   = (done && rx_valid_q && !rx_ready) ? 1'b1 : (xfer ? 1'b0 : overrun_q);
    frame_err_d = ferr;
  end
endmodule

// File: tb/tb_uart_rx_unit.sv
// tb_uart_rx_unit: directed frame tests for uart_rx_unit at 16 clk per bit
module tb_uart_rx_unit;
  logic       clk = 0, reset = 1, uart_rx = 1, rx_ready = 0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun;
  int         checks = 0, passed = 0, fe_cnt = 0, fe0;

  uart_rx_unit #(.CLK_FREQ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk(clk), .reset(reset), .uart_rx(uart_rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err) fe_cnt++;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tk(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(logic [7:0] d, logic stop);
    uart_rx = 0;
    tk(16);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      tk(16);
    end
    uart_rx = stop;
    tk(16);
  endtask

  task automatic accept;
    rx_ready = 1;
    tk(1);
    rx_ready = 0;
  endtask

  task automatic wait_valid;
    for (int i = 0; i < 4 && !rx_valid; i++) tk(1);
  endtask

  initial begin
    tk(2);
    check("rst_data", rx_data, 0);
    check("rst_valid", rx_valid, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    reset = 0;
    tk(4);

    fe0 = fe_cnt;
    send(8'hA5, 1);
    wait_valid;
    check("a5_valid", rx_valid, 1);
    check("a5_data", rx_data, 8'hA5);
    check("a5_ferr", fe_cnt - fe0, 0);
    accept;
    check("a5_taken", rx_valid, 0);

    fe0 = fe_cnt;
    uart_rx = 0;
    tk(4);
    uart_rx = 1;
    tk(40);
    check("glitch_valid", rx_valid, 0);
    check("glitch_ferr", fe_cnt - fe0, 0);

    fe0 = fe_cnt;
    send(8'h3C, 0);
    tk(16);
    uart_rx = 1;
    tk(20);
    check("fe_pulse", fe_cnt - fe0, 1);
    check("fe_valid", rx_valid, 0);
    send(8'h11, 1);
    wait_valid;
    check("after_fe_valid", rx_valid, 1);
    check("after_fe_data", rx_data, 8'h11);
    accept;

    tk(4);
    send(8'h12, 1);
    tk(4);
    send(8'h34, 1);
    wait_valid;
    check("ovr_data", rx_data, 8'h34);
    check("ovr_valid", rx_valid, 1);
    check("ovr_flag", overrun, 1);
    accept;
    check("ovr_clr", overrun, 0);
    check("ovr_taken", rx_valid, 0);

    tk(4);
    send(8'h56, 1);
    tk(4);
    check("sim_first", rx_data, 8'h56);
    fork
      send(8'h78, 1);
      begin
        tk(154);
        rx_ready = 1;
        tk(1);
        rx_ready = 0;
      end
    join
    check("sim_data", rx_data, 8'h78);
    check("sim_valid", rx_valid, 1);
    check("sim_ovr", overrun, 0);

    tk(4);
    fork
      send(8'hFF, 1);
      begin
        tk(60);
        reset = 1;
        #1;
        check("mid_rst_data", rx_data, 0);
        check("mid_rst_valid", rx_valid, 0);
        check("mid_rst_ovr", overrun, 0);
        check("mid_rst_ferr", frame_err, 0);
      end
    join
    tk(2);
    reset = 0;
    tk(4);
    send(8'h5A, 1);
    wait_valid;
    check("post_rst_valid", rx_valid, 1);
    check("post_rst_data", rx_data, 8'h5A);
    check("post_rst_ovr", overrun, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
